// File: rtl/multicore_timer_pkg.sv
// Shared definitions for the multicore timer driver: timer register map,
// control bit positions, FSM state enum and Avalon-MM bus helpers.
package multicore_timer_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RUN,
    ST_CLR_STS,
    ST_WR_STOP
`ifdef MULTICORE_TIMER_DRIVER_SNAPSHOT_EN
    ,
    ST_SNAP_WR,
    ST_SNAP_RL,
    ST_SNAP_RH,
    ST_SNAP_CAP
`endif
  } state_t;

  typedef struct packed {
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{address: 3'd0, chipselect: 1'b0,
                                write_n: 1'b1, writedata: 16'h0000};

  function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
    bus_t b;
    b.address    = addr;
    b.chipselect = 1'b1;
    b.write_n    = 1'b0;
    b.writedata  = data;
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [2:0] addr);
    bus_t b;
    b.address    = addr;
    b.chipselect = 1'b1;
    b.write_n    = 1'b1;
    b.writedata  = 16'h0000;
    return b;
  endfunction

  function automatic logic [15:0] ctrl_start_word(input logic cont);
    logic [15:0] w;
    // NOTE: every bit gets a value before any is overridden, so no path
    // leaves a bit unassigned (the same rule that prevents latches in comb logic).
    w             = 16'h0000;
    w[CTRL_ITO]   = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] ctrl_stop_word();
    logic [15:0] w;
    w            = 16'h0000;
    w[CTRL_ITO]  = 1'b1;
    w[CTRL_STOP] = 1'b1;
    return w;
  endfunction

  // Returns {busy, running} for the state being entered.
  function automatic logic [1:0] state_flags(input state_t s);
    logic busy_f;
    logic running_f;
    busy_f    = (s != ST_IDLE) && (s != ST_RUN);
    running_f = !(s inside {ST_IDLE, ST_WR_PL, ST_WR_PH, ST_WR_CTRL});
    return {busy_f, running_f};
  endfunction

endpackage

// File: rtl/multicore_timer_driver.sv
// Avalon-MM master that programs, services and snapshots an interval timer.
// Snapshot path is built only when MULTICORE_TIMER_DRIVER_SNAPSHOT_EN is defined.
module multicore_timer_driver
  import multicore_timer_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              snap_req,
  input  logic [31:0]       period,
  input  logic              continuous,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [15:0]       writedata,
  input  logic [15:0]       readdata,
  input  logic              irq,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid
);

  state_t            r_state;
  bus_t              r_bus;
  logic              r_busy;
  logic              r_running;
  logic              r_tick;
  logic [TICK_W-1:0] r_tick_count;
  logic [15:0]       r_period_h;
  logic              r_cont;

`ifdef MULTICORE_TIMER_DRIVER_SNAPSHOT_EN
  logic [15:0]       r_snap_lo;
  logic [31:0]       r_snap_value;
  logic              r_snap_valid;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_bus        <= BUS_IDLE;
      r_busy       <= 1'b0;
      r_running    <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
      r_period_h   <= '0;
      r_cont       <= 1'b0;
`ifdef MULTICORE_TIMER_DRIVER_SNAPSHOT_EN
      r_snap_lo    <= '0;
      r_snap_value <= '0;
      r_snap_valid <= 1'b0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments so every register in this
      // block updates from the same pre-edge values, independent of statement order.
      r_bus  <= BUS_IDLE;
      r_tick <= 1'b0;
`ifdef MULTICORE_TIMER_DRIVER_SNAPSHOT_EN
      r_snap_valid <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_period_h               <= period[31:16];
            r_cont                   <= continuous;
            r_bus                    <= bus_write(ADDR_PERIOD_L, period[15:0]);
            r_state                  <= ST_WR_PL;
            {r_busy, r_running}      <= state_flags(ST_WR_PL);
          end
        end

        ST_WR_PL: begin
          r_bus               <= bus_write(ADDR_PERIOD_H, r_period_h);
          r_state             <= ST_WR_PH;
          {r_busy, r_running} <= state_flags(ST_WR_PH);
        end

        ST_WR_PH: begin
          r_bus               <= bus_write(ADDR_CONTROL, ctrl_start_word(r_cont));
          r_state             <= ST_WR_CTRL;
          {r_busy, r_running} <= state_flags(ST_WR_CTRL);
        end

        ST_WR_CTRL: begin
          r_state             <= ST_RUN;
          {r_busy, r_running} <= state_flags(ST_RUN);
        end

        // Only the highest-priority request is taken; the others are dropped.
        ST_RUN: begin
          if (irq) begin
            r_bus               <= bus_write(ADDR_STATUS, 16'h0000);
            r_tick              <= 1'b1;
            r_tick_count        <= r_tick_count + 1'b1;
            r_state             <= ST_CLR_STS;
            {r_busy, r_running} <= state_flags(ST_CLR_STS);
          end else if (stop) begin
            r_bus               <= bus_write(ADDR_CONTROL, ctrl_stop_word());
            r_state             <= ST_WR_STOP;
            {r_busy, r_running} <= state_flags(ST_WR_STOP);
          end
`ifdef MULTICORE_TIMER_DRIVER_SNAPSHOT_EN
          else if (snap_req) begin
            r_bus               <= bus_write(ADDR_SNAP_L, 16'h0000);
            r_state             <= ST_SNAP_WR;
            {r_busy, r_running} <= state_flags(ST_SNAP_WR);
          end
`endif
        end

        ST_CLR_STS: begin
          if (r_cont) begin
            r_state             <= ST_RUN;
            {r_busy, r_running} <= state_flags(ST_RUN);
          end else begin
            r_state             <= ST_IDLE;
            {r_busy, r_running} <= state_flags(ST_IDLE);
          end
        end

        ST_WR_STOP: begin
          r_state             <= ST_IDLE;
          {r_busy, r_running} <= state_flags(ST_IDLE);
        end

`ifdef MULTICORE_TIMER_DRIVER_SNAPSHOT_EN
        ST_SNAP_WR: begin
          r_bus               <= bus_read(ADDR_SNAP_L);
          r_state             <= ST_SNAP_RL;
          {r_busy, r_running} <= state_flags(ST_SNAP_RL);
        end

        ST_SNAP_RL: begin
          r_bus               <= bus_read(ADDR_SNAP_H);
          r_state             <= ST_SNAP_RH;
          {r_busy, r_running} <= state_flags(ST_SNAP_RH);
        end

        // readdata lags the presented address by one cycle.
        ST_SNAP_RH: begin
          r_snap_lo           <= readdata;
          r_state             <= ST_SNAP_CAP;
          {r_busy, r_running} <= state_flags(ST_SNAP_CAP);
        end

        ST_SNAP_CAP: begin
          r_snap_value        <= {readdata, r_snap_lo};
          r_snap_valid        <= 1'b1;
          r_state             <= ST_RUN;
          {r_busy, r_running} <= state_flags(ST_RUN);
        end
`endif

        default: begin
          r_state             <= ST_IDLE;
          {r_busy, r_running} <= state_flags(ST_IDLE);
        end
      endcase
    end
  end

  assign address    = r_bus.address;
  assign chipselect = r_bus.chipselect;
  assign write_n    = r_bus.write_n;
  assign writedata  = r_bus.writedata;
  assign busy       = r_busy;
  assign running    = r_running;
  assign tick       = r_tick;
  assign tick_count = r_tick_count;

`ifdef MULTICORE_TIMER_DRIVER_SNAPSHOT_EN
  assign snap_value = r_snap_value;
  assign snap_valid = r_snap_valid;
`else
  logic w_unused_snap;
  assign w_unused_snap = ^{snap_req, readdata};
  assign snap_value    = 32'h0000_0000;
  assign snap_valid    = 1'b0;
`endif

endmodule
